ones_frame_accumulator: RTL

- Downstream stage of the per-byte population counter.
- Consumes a stream of 4-bit per-byte ones counts (legal range 0..8) framed by a last marker, and accumulates a per-frame total ones count and byte count.
- Presents one frame result at a time on a valid/ready output port, holding it until the consumer accepts it.
- Sits between the combinational popcount and the result/reporting logic.

---
 rtl/ones_frame_accumulator_pkg.sv | 16 +
 rtl/ones_frame_accumulator_sat_adder.sv | 21 ++
 rtl/ones_frame_accumulator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ones_frame_accumulator_pkg.sv
// Shared types and constants for the per-frame ones-count accumulator and
// related statistics stages.
package ones_frame_accumulator_pkg;

    typedef enum logic {
        StAccum = 1'b0,
        StHold  = 1'b1
    } acc_state_e;

    // Largest per-byte ones count that a legal popcount can produce.
    localparam logic [3:0] MaxCount = 4'd8;

    localparam int unsigned DefaultTotalW = 12;
    localparam int unsigned DefaultBytesW = 9;

endpackage

// File: rtl/ones_frame_accumulator_sat_adder.sv
// Saturating accumulator adder: acc + 4-bit addend, clamped to all-ones with
// an overflow flag raised whenever the true sum does not fit.
module ones_frame_accumulator_sat_adder #(
    parameter int unsigned Width = 12
) (
    input  logic [Width-1:0] acc_i,
    input  logic [3:0]       addend_i,
    output logic [Width-1:0] sum_o,
    output logic             ovf_o
);

    logic [Width:0] sum_full;

    // One extra bit catches the carry-out; requires Width >= 4.
    always_comb begin
        sum_full = {1'b0, acc_i} + {{(Width - 3){1'b0}}, addend_i};
        ovf_o    = sum_full[Width];
        sum_o    = sum_full[Width] ? {Width{1'b1}} : sum_full[Width-1:0];
    end

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates per-byte ones counts into per-frame totals and presents one
// frame result at a time on a valid/ready output.
module ones_frame_accumulator
    import ones_frame_accumulator_pkg::*;
#(
    parameter int unsigned TOTAL_W   = DefaultTotalW,
    parameter int unsigned MAX_BYTES = 256,
    parameter int unsigned BYTES_W   = DefaultBytesW
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [3:0]         in_count_i,
    input  logic               in_last_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [TOTAL_W-1:0] out_total_o,
    output logic [BYTES_W-1:0] out_bytes_o,
    output logic               out_overflow_o,
    output logic               out_bad_o,
    output logic               out_trunc_o,
    output logic               out_parity_o
);

    localparam logic [BYTES_W-1:0] MaxBytesC = BYTES_W'(MAX_BYTES);

    acc_state_e state_q, state_d;

    logic [TOTAL_W-1:0] acc_total_q;
    logic [BYTES_W-1:0] acc_bytes_q;
    logic               acc_ovf_q;
    logic               acc_bad_q;

    logic [TOTAL_W-1:0] out_total_q;
    logic [BYTES_W-1:0] out_bytes_q;
    logic               out_overflow_q;
    logic               out_bad_q;
    logic               out_trunc_q;
    logic               out_parity_q;

    logic               beat;
    logic               count_bad;
    logic [3:0]         eff_count;
    logic [TOTAL_W-1:0] new_total;
    logic               add_ovf;
    logic [BYTES_W-1:0] new_bytes;
    logic               close;

    always_comb begin
        beat      = in_valid_i & in_ready_o;
        count_bad = in_count_i > MaxCount;
        eff_count = count_bad ? MaxCount : in_count_i;
        new_bytes = acc_bytes_q + BYTES_W'(1);
        close     = beat & (in_last_i | (new_bytes == MaxBytesC));
    end

    ones_frame_accumulator_sat_adder #(
        .Width (TOTAL_W)
    ) u_sat_adder (
        .acc_i    (acc_total_q),
        .addend_i (eff_count),
        .sum_o    (new_total),
        .ovf_o    (add_ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (close) state_d = StHold;
            StHold:  if (out_ready_i) state_d = StAccum;
        endcase
    end

    // Handshake outputs depend only on registered state: no in_valid -> in_ready path.
    always_comb begin
        in_ready_o  = (state_q == StAccum);
        out_valid_o = (state_q == StHold);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_total_q <= '0;
            acc_bytes_q <= '0;
            acc_ovf_q   <= 1'b0;
            acc_bad_q   <= 1'b0;
        end else if (beat) begin
            if (close) begin
                acc_total_q <= '0;
                acc_bytes_q <= '0;
                acc_ovf_q   <= 1'b0;
                acc_bad_q   <= 1'b0;
            end else begin
                acc_total_q <= new_total;
                acc_bytes_q <= new_bytes;
                acc_ovf_q   <= acc_ovf_q | add_ovf;
                acc_bad_q   <= acc_bad_q | count_bad;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_total_q    <= '0;
            out_bytes_q    <= '0;
            out_overflow_q <= 1'b0;
            out_bad_q      <= 1'b0;
            out_trunc_q    <= 1'b0;
            out_parity_q   <= 1'b0;
        end else if (close) begin
            out_total_q    <= new_total;
            out_bytes_q    <= new_bytes;
            out_overflow_q <= acc_ovf_q | add_ovf;
            out_bad_q      <= acc_bad_q | count_bad;
            out_trunc_q    <= ~in_last_i;
            out_parity_q   <= new_total[0];
        end
    end

    assign out_total_o    = out_total_q;
    assign out_bytes_o    = out_bytes_q;
    assign out_overflow_o = out_overflow_q;
    assign out_bad_o      = out_bad_q;
    assign out_trunc_o    = out_trunc_q;
    assign out_parity_o   = out_parity_q;

endmodule
